// File: rtl/dac_pack_if.sv
// Stream bundle around the dual-channel DAC packer: two sample inputs and one packed output.
// Handshake: a channel beat transfers on a rising clk edge where tvalid=1 and tready=1; the DAC
// side has no tready and takes M_AXIS_DAC_tdata on every edge where M_AXIS_DAC_tvalid=1.
interface dac_pack_if;
  logic [31:0] S_AXIS_CHA_tdata;
  logic        S_AXIS_CHA_tvalid;
  logic        S_AXIS_CHA_tready;
  logic [31:0] S_AXIS_CHB_tdata;
  logic        S_AXIS_CHB_tvalid;
  logic        S_AXIS_CHB_tready;
  logic [31:0] M_AXIS_DAC_tdata;
  logic        M_AXIS_DAC_tvalid;

  modport master (
    output S_AXIS_CHA_tdata, S_AXIS_CHA_tvalid,
    input  S_AXIS_CHA_tready,
    output S_AXIS_CHB_tdata, S_AXIS_CHB_tvalid,
    input  S_AXIS_CHB_tready,
    input  M_AXIS_DAC_tdata, M_AXIS_DAC_tvalid
  );

  modport slave (
    input  S_AXIS_CHA_tdata, S_AXIS_CHA_tvalid,
    output S_AXIS_CHA_tready,
    input  S_AXIS_CHB_tdata, S_AXIS_CHB_tvalid,
    output S_AXIS_CHB_tready,
    output M_AXIS_DAC_tdata, M_AXIS_DAC_tvalid
  );
endinterface

// File: rtl/dac_pack.sv
// Packs two sample-and-hold control channels into one 32-bit dual-channel DAC word,
// with per-channel scaling, 14-bit saturation, staleness watchdog and clip counters.
module dac_pack #(
  parameter int IN_WIDTH     = 16,
  parameter int SHIFT        = 0,
  parameter int OFFSET_BIN   = 0,
  parameter int STALE_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  dac_pack_if.slave        bus,
  input  logic             clr_stats,
  output logic [1:0]       stale,
  output logic [15:0]      sat_count_a,
  output logic [15:0]      sat_count_b
);

  localparam int          CW        = $clog2(STALE_CYCLES + 1);
  localparam logic [CW-1:0] WD_MAX  = CW'(STALE_CYCLES);
  localparam logic [CW-1:0] WD_LAST = CW'(STALE_CYCLES - 1);
  localparam logic [13:0] CODE_INV  = (OFFSET_BIN != 0) ? 14'h2000 : 14'h0000;

  logic                ready_q;
  logic                out_vld;
  logic [31:0]         in_data  [2];
  logic                in_vld   [2];
  logic                accept   [2];
  logic [IN_WIDTH-1:0] s0_data  [2];
  logic                s0_vld   [2];
  logic [14:0]         sat_res  [2];
  logic [13:0]         s1_code  [2];
  logic                s1_vld   [2];
  logic [13:0]         hold     [2];
  logic [CW-1:0]       wd_cnt   [2];
  logic [15:0]         sat_cnt  [2];

  // {clip, code}: floor shift then clamp to the 14-bit signed range.
  function automatic logic [14:0] saturate(input logic [IN_WIDTH-1:0] d);
    logic signed [IN_WIDTH-1:0] xs;
    logic signed [32:0]         xw;
    xs = $signed(d) >>> SHIFT;
    xw = {{(33 - IN_WIDTH){xs[IN_WIDTH-1]}}, xs};
    if (xw > 33'sd8191)
      return {1'b1, 14'h1FFF};
    else if (xw < -33'sd8192)
      return {1'b1, 14'h2000};
    else
      return {1'b0, xw[13:0]};
  endfunction

  assign in_data[0] = bus.S_AXIS_CHA_tdata;
  assign in_data[1] = bus.S_AXIS_CHB_tdata;
  assign in_vld[0]  = bus.S_AXIS_CHA_tvalid;
  assign in_vld[1]  = bus.S_AXIS_CHB_tvalid;

  generate
    if (IN_WIDTH < 32) begin : g_unused
      logic unused_hi;
      assign unused_hi = ^{in_data[0][31:IN_WIDTH], in_data[1][31:IN_WIDTH]};
    end
  endgenerate

  always_comb begin
    for (int c = 0; c < 2; c++) begin
      accept[c]  = in_vld[c] & ready_q;
      sat_res[c] = saturate(s0_data[c]);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ready_q <= 1'b0;
      out_vld <= 1'b0;
      stale   <= 2'b00;
      for (int c = 0; c < 2; c++) begin
        s0_data[c] <= '0;
        s0_vld[c]  <= 1'b0;
        s1_code[c] <= '0;
        s1_vld[c]  <= 1'b0;
        hold[c]    <= '0;
        wd_cnt[c]  <= '0;
        sat_cnt[c] <= '0;
      end
    end else begin
      ready_q <= 1'b1;
      out_vld <= 1'b1;
      for (int c = 0; c < 2; c++) begin
        s0_vld[c] <= accept[c];
        if (accept[c])
          s0_data[c] <= in_data[c][IN_WIDTH-1:0];

        s1_vld[c] <= s0_vld[c];
        if (s0_vld[c])
          s1_code[c] <= sat_res[c][13:0];

        if (accept[c]) begin
          wd_cnt[c] <= '0;
          stale[c]  <= 1'b0;
        end else if (wd_cnt[c] != WD_MAX) begin
          wd_cnt[c] <= wd_cnt[c] + 1'b1;
        end

        // The stale force wins over any code arriving on the same edge.
        if (!accept[c] && wd_cnt[c] == WD_LAST) begin
          stale[c] <= 1'b1;
          hold[c]  <= '0;
        end else if (s1_vld[c]) begin
          hold[c] <= s1_code[c];
        end

        if (clr_stats)
          sat_cnt[c] <= '0;
        else if (s0_vld[c] && sat_res[c][14] && sat_cnt[c] != 16'hFFFF)
          sat_cnt[c] <= sat_cnt[c] + 16'd1;
      end
    end
  end

  assign bus.S_AXIS_CHA_tready = ready_q;
  assign bus.S_AXIS_CHB_tready = ready_q;
  assign bus.M_AXIS_DAC_tvalid = out_vld;
  assign bus.M_AXIS_DAC_tdata  = {2'b00, hold[1] ^ CODE_INV, 2'b00, hold[0] ^ CODE_INV};
  assign sat_count_a = sat_cnt[0];
  assign sat_count_b = sat_cnt[1];

endmodule
